nonce_target_check: RTL and testbench

//  Downstream stage of the SHA-256 nonce hasher. Once the hasher has written
//  NUM_NONCES 32-bit hash words to memory, this block reads them back, compares

---
 rtl/nonce_target_check.sv | 158 +++++++++++++++
 tb/tb_nonce_target_check.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nonce_target_check.sv
// Scans NUM_NONCES hash words in memory against a 32-bit target and writes a result record.
// Optional NONCE_MIN_HASH_EN: also tracks the minimum hash and writes it to result_addr+1.
module nonce_target_check #(
    parameter int NUM_NONCES = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] hash_addr,
    input  logic [15:0] target_addr,
    input  logic [15:0] result_addr,
    output logic        done,
    output logic        found,
    output logic [7:0]  nonce_idx,
    output logic        mem_clk,
    output logic        mem_we,
    output logic [15:0] memory_addr,
    output logic [31:0] memory_write_data,
    input  logic [31:0] memory_read_data
);

    localparam int CW = $clog2(NUM_NONCES + 1);
    localparam logic [CW-1:0] LAST = CW'(NUM_NONCES);

    typedef enum logic [2:0] {
        IDLE,
        READ_T,
        SCAN,
        WR_STAT,
        WR_MIN,
        DONE
    } state_t;

    state_t        state, next_state;
    logic [CW-1:0] cnt;
    logic [15:0]   hash_base, target_base, result_base;
    logic [31:0]   target_q;
    logic          found_q;
    logic [7:0]    idx_q;
    logic [7:0]    scan_idx;
    logic [7:0]    min_idx_field;
    logic [31:0]   status_word;

`ifdef NONCE_MIN_HASH_EN
    logic [31:0]   min_hash;
    logic [7:0]    min_idx;
    assign min_idx_field = min_idx;
`else
    assign min_idx_field = 8'h00;
`endif

    assign mem_clk     = clk;
    assign found       = found_q;
    assign nonce_idx   = idx_q;
    // Read data in SCAN belongs to the word addressed one cycle earlier.
    assign scan_idx    = 8'(cnt - CW'(1));
    assign status_word = {found_q, 15'b0, min_idx_field, idx_q};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; reset here is synchronous (inside the clocked block).
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: next_state gets a default before the case so no latch is inferred.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = READ_T;
            READ_T:  next_state = SCAN;
            SCAN:    if (cnt == LAST) next_state = WR_STAT;
`ifdef NONCE_MIN_HASH_EN
            WR_STAT: next_state = WR_MIN;
            WR_MIN:  next_state = DONE;
`else
            WR_STAT: next_state = DONE;
`endif
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt         <= '0;
            hash_base   <= '0;
            target_base <= '0;
            result_base <= '0;
            target_q    <= '0;
            found_q     <= 1'b0;
            idx_q       <= '0;
`ifdef NONCE_MIN_HASH_EN
            min_hash    <= '0;
            min_idx     <= '0;
`endif
        end else if (state == IDLE && start) begin
            cnt         <= '0;
            hash_base   <= hash_addr;
            target_base <= target_addr;
            result_base <= result_addr;
            found_q     <= 1'b0;
            idx_q       <= '0;
`ifdef NONCE_MIN_HASH_EN
            min_hash    <= '0;
            min_idx     <= '0;
`endif
        end else if (state == SCAN) begin
            cnt <= cnt + CW'(1);
            if (cnt == '0) begin
                target_q <= memory_read_data;
            end else begin
                // Only the first hit is recorded.
                if (!found_q && (memory_read_data < target_q)) begin
                    found_q <= 1'b1;
                    idx_q   <= scan_idx;
                end
`ifdef NONCE_MIN_HASH_EN
                // Strict compare keeps the lower index on ties.
                if (cnt == CW'(1) || memory_read_data < min_hash) begin
                    min_hash <= memory_read_data;
                    min_idx  <= scan_idx;
                end
`endif
            end
        end
    end

    always_comb begin
        mem_we            = 1'b0;
        memory_addr       = 16'h0000;
        memory_write_data = 32'h0000_0000;
        done              = 1'b0;
        case (state)
            READ_T:  memory_addr = target_base;
            // The final SCAN cycle only compares; its extra read is discarded.
            SCAN:    memory_addr = hash_base + 16'(cnt);
            WR_STAT: begin
                mem_we            = 1'b1;
                memory_addr       = result_base;
                memory_write_data = status_word;
            end
`ifdef NONCE_MIN_HASH_EN
            WR_MIN:  begin
                mem_we            = 1'b1;
                memory_addr       = result_base + 16'd1;
                memory_write_data = min_hash;
            end
`endif
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_nonce_target_check.sv
// Scoreboard bench for nonce_target_check: directed scans, expectations queued at launch,
// monitor pops one record per done pulse and checks results, record writes and latency.
module tb_nonce_target_check;

    localparam int N = 16;
`ifdef NONCE_MIN_HASH_EN
    localparam int LAT = N + 5;
    localparam int NW  = 2;
`else
    localparam int LAT = N + 4;
    localparam int NW  = 1;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] hash_addr = '0, target_addr = '0, result_addr = '0;
    logic        done, found, mem_clk, mem_we;
    logic [7:0]  nonce_idx;
    logic [15:0] memory_addr;
    logic [31:0] memory_write_data;
    logic [31:0] memory_read_data = '0;

    logic [31:0] mem [0:65535];

    typedef struct {
        int          c0;
        logic        found;
        logic [7:0]  idx;
        logic [31:0] status;
        logic [31:0] min;
        logic [15:0] raddr;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0, n_err = 0;
    int   cyc = 0;
    int   wr_count = 0, done_count = 0;
    logic [15:0] wr_addr0, wr_addr1;
    logic [31:0] wr_data0, wr_data1;

    nonce_target_check #(.NUM_NONCES(N)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .hash_addr(hash_addr), .target_addr(target_addr), .result_addr(result_addr),
        .done(done), .found(found), .nonce_idx(nonce_idx),
        .mem_clk(mem_clk), .mem_we(mem_we), .memory_addr(memory_addr),
        .memory_write_data(memory_write_data), .memory_read_data(memory_read_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) memory_read_data <= mem[memory_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: captures record writes and scores each done pulse against the queue.
    initial begin
        exp_t e;
        wr_addr0 = '0; wr_addr1 = '0; wr_data0 = '0; wr_data1 = '0;
        forever begin
            @(negedge clk);
            if (mem_we) begin
                wr_count++;
                if (wr_count == 1) begin
                    wr_addr0 = memory_addr; wr_data0 = memory_write_data;
                end else begin
                    wr_addr1 = memory_addr; wr_data1 = memory_write_data;
                end
            end
            if (done) begin
                if (q.size() == 0) begin
                    check("spurious_done", 32'(done), 32'd0);
                end else begin
                    e = q.pop_front();
                    check("found", 32'(found), 32'(e.found));
                    check("nonce_idx", 32'(nonce_idx), 32'(e.idx));
                    check("done_latency", 32'(cyc - e.c0), 32'(LAT));
                    check("write_count", 32'(wr_count), 32'(NW));
                    check("status_addr", 32'(wr_addr0), 32'(e.raddr));
                    check("status_word", wr_data0, e.status);
`ifdef NONCE_MIN_HASH_EN
                    check("min_addr", 32'(wr_addr1), 32'(e.raddr + 16'd1));
                    check("min_word", wr_data1, e.min);
`endif
                end
                wr_count = 0;
                done_count++;
            end
        end
    end

    task automatic fill(input logic [15:0] base, input logic [31:0] v);
        for (int i = 0; i < N; i++) mem[16'(base + 16'(i))] = v;
    endtask

    task automatic push_exp(input int c0, input logic f, input logic [7:0] idx,
                            input logic [31:0] st_en, input logic [31:0] st_dis,
                            input logic [31:0] mn, input logic [15:0] r);
        exp_t e;
        e.c0 = c0; e.found = f; e.idx = idx; e.min = mn; e.raddr = r;
`ifdef NONCE_MIN_HASH_EN
        e.status = st_en;
`else
        e.status = st_dis;
`endif
        q.push_back(e);
    endtask

    // Returns C0 of the launched scan; start is sampled at the next rising edge.
    task automatic launch(input logic [15:0] h, input logic [15:0] t, input logic [15:0] r,
                          input logic f, input logic [7:0] idx, input logic [31:0] st_en,
                          input logic [31:0] st_dis, input logic [31:0] mn, output int c0);
        @(negedge clk);
        hash_addr = h; target_addr = t; result_addr = r;
        start = 1'b1;
        c0 = cyc;
        push_exp(c0, f, idx, st_en, st_dis, mn, r);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        if (q.size() != 0) begin
            check("drain_timeout", 32'(q.size()), 32'd0);
            q.delete();
        end
    endtask

    initial begin
        int c0, dc, n;
        for (int i = 0; i < 65536; i++) mem[i] = 32'h0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_done", 32'(done), 0);
        check("rst_found", 32'(found), 0);
        check("rst_nonce_idx", 32'(nonce_idx), 0);
        check("rst_mem_we", 32'(mem_we), 0);
        check("rst_memory_addr", 32'(memory_addr), 0);
        check("rst_write_data", memory_write_data, 0);
        reset_n = 1'b1;

        // 1: single hit at index 5
        fill(16'h1000, 32'hFFFF_FFFF);
        mem[16'h1005] = 32'h0000_FFFF;
        mem[16'h4000] = 32'h0001_0000;
        launch(16'h1000, 16'h4000, 16'h5000, 1'b1, 8'd5, 32'h8000_0505, 32'h8000_0005,
               32'h0000_FFFF, c0);
        drain();

        // 2: two equal hits, first wins; min tie keeps lower index
        fill(16'h1000, 32'hFFFF_FFFF);
        mem[16'h1003] = 32'h0000_0010;
        mem[16'h1009] = 32'h0000_0010;
        mem[16'h4000] = 32'h0000_1000;
        launch(16'h1000, 16'h4000, 16'h5000, 1'b1, 8'd3, 32'h8000_0303, 32'h8000_0003,
               32'h0000_0010, c0);
        drain();

        // 3: equality is not a hit
        fill(16'h1000, 32'h2000_0000);
        mem[16'h1007] = 32'h1234_5678;
        mem[16'h4000] = 32'h1234_5678;
        launch(16'h1000, 16'h4000, 16'h5000, 1'b0, 8'd0, 32'h0000_0700, 32'h0000_0000,
               32'h1234_5678, c0);
        drain();

        // target = 0: never found; all-equal minimum stays at index 0
        fill(16'h1000, 32'h0000_0000);
        mem[16'h4000] = 32'h0000_0000;
        launch(16'h1000, 16'h4000, 16'h5000, 1'b0, 8'd0, 32'h0000_0000, 32'h0000_0000,
               32'h0000_0000, c0);
        drain();

        // target = FFFFFFFF: only the last word (FFFFFFFE) hits
        fill(16'h1000, 32'hFFFF_FFFF);
        mem[16'h100F] = 32'hFFFF_FFFE;
        mem[16'h4000] = 32'hFFFF_FFFF;
        launch(16'h1000, 16'h4000, 16'h5000, 1'b1, 8'd15, 32'h8000_0F0F, 32'h8000_000F,
               32'hFFFF_FFFE, c0);
        drain();

        // 4: hash window wraps 0xFFF8..0x0007; hit at index 10 = address 0x0002
        fill(16'hFFF8, 32'hFFFF_FFFF);
        mem[16'h0002] = 32'h0000_0005;
        mem[16'h4000] = 32'h0000_0100;
        launch(16'hFFF8, 16'h4000, 16'h5000, 1'b1, 8'd10, 32'h8000_0A0A, 32'h8000_000A,
               32'h0000_0005, c0);
        drain();

        // 5a: reset at C6 abandons the scan: no write, no done
        fill(16'h1000, 32'hFFFF_FFFF);
        mem[16'h1005] = 32'h0000_FFFF;
        mem[16'h4000] = 32'h0001_0000;
        dc = done_count;
        @(negedge clk);
        hash_addr = 16'h1000; target_addr = 16'h4000; result_addr = 16'h5000;
        start = 1'b1;
        c0 = cyc;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (cyc != c0 + 6 && n < 20) begin
            @(negedge clk);
            n++;
        end
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("abort_done", 32'(done), 0);
        check("abort_mem_we", 32'(mem_we), 0);
        check("abort_memory_addr", 32'(memory_addr), 0);
        check("abort_found", 32'(found), 0);
        repeat (N + 10) @(negedge clk);
        check("abort_done_count", 32'(done_count), 32'(dc));
        check("abort_write_count", 32'(wr_count), 0);

        // 5b: start pulsed mid-scan is ignored; latency unchanged
        launch(16'h1000, 16'h4000, 16'h5000, 1'b1, 8'd5, 32'h8000_0505, 32'h8000_0005,
               32'h0000_FFFF, c0);
        n = 0;
        while (cyc != c0 + 5 && n < 20) begin
            @(negedge clk);
            n++;
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();

        // start held high re-triggers in the cycle after DONE
        @(negedge clk);
        hash_addr = 16'h1000; target_addr = 16'h4000; result_addr = 16'h5000;
        start = 1'b1;
        c0 = cyc;
        push_exp(c0, 1'b1, 8'd5, 32'h8000_0505, 32'h8000_0005, 32'h0000_FFFF, 16'h5000);
        push_exp(c0 + LAT + 1, 1'b1, 8'd5, 32'h8000_0505, 32'h8000_0005, 32'h0000_FFFF,
                 16'h5000);
        n = 0;
        while (q.size() > 1 && n < 100) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        drain();
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
